// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains an upstream FIFO: one pop per frame, then start bit,
// DATA_WIDTH bits LSB first and a stop bit of SB_TICK oversample ticks.
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR       = 54
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int CW   = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int TMAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] BAUD_LAST      = CW'(DVSR - 1);
  localparam logic [TW-1:0] DATA_TICK_LAST = TW'(15);
  localparam logic [TW-1:0] STOP_TICK_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST       = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic                  tx_q, tx_d;
  logic                  s_tick;

  assign s_tick  = (baud_q == BAUD_LAST);
  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    sreg_d       = sreg_q;
    rd           = 1'b0;
    tx_done_tick = 1'b0;
    baud_d       = (state_q == IDLE || s_tick) ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          rd      = 1'b1;
          sreg_d  = r_data;
          tick_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == DATA_TICK_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == DATA_TICK_LAST) begin
            tick_d = '0;
            sreg_d = sreg_q >> 1;
            if (bit_q == BIT_LAST) state_d = STOP;
            else                   bit_d   = bit_q + 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == STOP_TICK_LAST) begin
            tx_done_tick = 1'b1;
            tick_d       = '0;
            state_d      = IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset wins over any pop or completion decided above in the same cycle.
    if (reset) begin
      rd           = 1'b0;
      tx_done_tick = 1'b0;
    end

    // tx is registered, so it is derived from where the FSM goes next.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx: FIFO model feeds words, a UART receiver model
// sampling at bit centres checks each popped word, frame timing and flags.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int DW    = 4;
  localparam int DVSR  = 2;
  localparam int SBT   = 16;
  localparam int BITC  = 16 * DVSR;
  localparam int FRAME = (1 + DW) * BITC + SBT * DVSR;

  logic          clk = 1'b0;
  logic          reset;
  logic          empty;
  logic [DW-1:0] r_data;
  logic          rd;
  logic          tx;
  logic          tx_busy;
  logic          tx_done_tick;

  fifo_uart_tx #(.DATA_WIDTH(DW), .SB_TICK(SBT), .DVSR(DVSR)) dut (
    .clk          (clk),
    .reset        (reset),
    .empty        (empty),
    .r_data       (r_data),
    .rd           (rd),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            done_q[$];
  int            rd_log[$];
  int            busy_start = 0;
  int            busy_end   = -1;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    empty = (fifo_q.size() == 0);
    r_data = empty ? DW'($urandom_range(0, 2**DW - 1)) : fifo_q[0];
  endtask

  // One clock: observe a pop at the negedge, apply it to the FIFO model after the edge.
  task automatic cycle();
    bit pop;
    pop = 1'b0;
    @(negedge clk);
    if (rd === 1'b1 && fifo_q.size() != 0) begin
      exp_q.push_back(fifo_q[0]);
      done_q.push_back(cyc + FRAME);
      rd_log.push_back(cyc);
      busy_start = cyc + 1;
      busy_end   = cyc + FRAME;
      pop = 1'b1;
    end
    @(posedge clk);
    #1;
    if (pop) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    drive_fifo();
  endtask

  task automatic wait_rd(output int k);
    int n0;
    int b;
    n0 = rd_log.size();
    b  = 0;
    while (rd_log.size() == n0 && b < 500) begin
      cycle();
      b++;
    end
    chk("wait_rd_timeout", rd_log.size() > n0, 1);
    k = (rd_log.size() > n0) ? rd_log[$] : cyc;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || done_q.size() != 0) && b < 12000) begin
      cycle();
      b++;
    end
    chk("drain_timeout", b < 12000, 1);
    repeat (3) cycle();
  endtask

  // Monitor: receiver model plus per-cycle flag checks.
  initial begin : monitor
    bit            rx_active;
    bit            rst_prev;
    bit            rd_prev;
    int            t0;
    int            off;
    logic [DW-1:0] rx_word;
    rx_active = 1'b0;
    rst_prev  = 1'b0;
    rd_prev   = 1'b0;
    t0        = 0;
    rx_word   = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        chk("rd_during_reset", rd, 0);
        rx_active = 1'b0;
      end else begin
        if (rst_prev) begin
          chk("post_reset_tx", tx, 1);
          chk("post_reset_busy", tx_busy, 0);
          chk("post_reset_done", tx_done_tick, 0);
        end
        if (rd === 1'b1) begin
          chk("rd_with_empty", empty, 0);
          chk("rd_back_to_back", rd_prev, 0);
        end
        chk("tx_busy", tx_busy, (cyc >= busy_start && cyc <= busy_end));

        if (!rx_active) begin
          if (tx === 1'b0) begin
            rx_active = 1'b1;
            t0 = cyc;
            chk("start_edge", cyc, (done_q.size() != 0) ? done_q[$] - FRAME + 1 : -1);
          end
        end else begin
          off = cyc - t0;
          if (off == BITC / 2) chk("start_bit", tx, 0);
          for (int i = 0; i < DW; i++)
            if (off == BITC / 2 + BITC * (i + 1)) rx_word[i] = tx;
          if (off == BITC / 2 + BITC * (DW + 1)) begin
            chk("stop_bit", tx, 1);
            chk("rx_word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("rx_word", rx_word, exp_q.pop_front());
            rx_active = 1'b0;
          end
        end

        if (tx_done_tick === 1'b1)
          chk("done_time", cyc, (done_q.size() != 0) ? done_q.pop_front() : -1);
        else if (done_q.size() != 0 && cyc > done_q[0]) begin
          chk("done_missing", cyc, done_q[0]);
          void'(done_q.pop_front());
        end
      end
      rst_prev = (reset === 1'b1);
      rd_prev  = (rd === 1'b1);
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k;
    int n0;
    reset  = 1'b1;
    empty  = 1'b1;
    r_data = '0;
    repeat (3) cycle();
    reset = 1'b0;

    // Idle line with an empty FIFO.
    repeat (50) cycle();
    chk("idle_rd_count", rd_log.size(), 0);

    // Single word: one pop, one frame.
    n0 = rd_log.size();
    push(4'b0110);
    wait_rd(k);
    drain();
    chk("single_rd_count", rd_log.size() - n0, 1);

    // Three queued words run back to back with one idle cycle between frames.
    n0 = rd_log.size();
    push(4'hA);
    push(4'h3);
    push(4'hF);
    drain();
    chk("b2b_rd_count", rd_log.size() - n0, 3);
    if (rd_log.size() - n0 == 3) begin
      chk("b2b_gap_1", rd_log[n0 + 1] - rd_log[n0], FRAME + 1);
      chk("b2b_gap_2", rd_log[n0 + 2] - rd_log[n0 + 1], FRAME + 1);
    end

    // FIFO write mid-DATA does not disturb the frame in flight.
    push(4'h5);
    wait_rd(k);
    repeat (80) cycle();
    push(4'hC);
    drain();
    chk("midframe_pop_cycle", rd_log[$], k + FRAME + 1);

    // Reset mid-frame aborts the word; the next queued word follows cleanly.
    push(4'h9);
    push(4'h6);
    wait_rd(k);
    while (cyc < k + 70) cycle();
    reset = 1'b1;
    exp_q.delete();
    done_q.delete();
    busy_end = cyc;
    cycle();
    reset = 1'b0;
    drain();
    chk("after_reset_pop_cycle", rd_log[$], k + 71);

    // Random traffic with random gaps and occasional bursts.
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(0, 260)) cycle();
      for (int j = 0; j < int'($urandom_range(1, 2)); j++)
        push(DW'($urandom_range(0, 2**DW - 1)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
